uart_tx_arbiter: RTL
====================

Name: uart_tx_arbiter

Overview:
- Shares one UART transmitter (tx_start / tx_data / tx_busy byte interface) between NUM_REQ byte-stream requesters.
- Round-robin grant at message granularity: the owner keeps the transmitter until it sends a byte flagged last, or until MAX_BURST bytes have gone out.
- Sits between on-chip producers (command responder, status reporter, loopback of receiver bytes) and the UART transmitter core.

Parameters:
- NUM_REQ, 4, number of requesters (2..8).
- Word_Len, 8, data bits per UART word.
- MAX_BURST, 16, maximum bytes per grant before forced release (1..255).

Ports:
- clk  in  1  system clock.
- reset  in  1  asynchronous, active-low reset.
- req_valid  in  NUM_REQ  requester i has a byte ready on its slice of req_data.
- req_data  in  NUM_REQ*Word_Len  packed bytes; slice i is [i*Word_Len +: Word_Len].
- req_last  in  NUM_REQ  the offered byte is the last byte of requester i's message.
- req_ready  out  NUM_REQ  one-cycle pulse: requester i's byte was accepted this cycle.
- grant  out  NUM_REQ  one-hot current owner; all zero when idle.
- tx_start  out  1  one-cycle pulse telling the transmitter to begin a word.
- tx_data  out  Word_Len  byte to transmit; stable from tx_start until tx_busy falls.
- tx_busy  in  1  transmitter busy; rises the cycle after tx_start and falls after the stop bit.

Behaviour:
- Reset (reset=0, asynchronous):
  - state = IDLE.
  - grant, req_ready, tx_start, tx_data are all zero.
  - rr pointer = 0; burst count = 0.
- All outputs are registered.
- IDLE:
  - If any req_valid is set, pick the first set index searching from ptr upward, with wrap-around.
  - Register grant = one-hot of that index; clear the burst count; go to LOAD.
  - With no requests, stay in IDLE with grant = 0.
- LOAD:
  - If req_valid[owner]=1 and tx_busy=0:
    - tx_data <= slice[owner]; tx_start <= 1 and req_ready[owner] <= 1, both for exactly one cycle.
    - Latch req_last[owner] into last_q; count <= count+1; go to WAIT_BUSY.
  - If req_valid[owner]=0: hold in LOAD with grant kept (message lock). Other requesters are not served.
- WAIT_BUSY:
  - Go to WAIT_DONE on tx_busy=1.
  - If tx_busy is still 0 after 4 cycles, go to WAIT_DONE anyway (lost-handshake guard).
- WAIT_DONE: on tx_busy=0:
  - If last_q=1 or count==MAX_BURST: release. grant <= 0; ptr <= owner+1 mod NUM_REQ; go to IDLE.
  - Otherwise go to LOAD.
- Latency:
  - req_valid sampled in IDLE at edge N gives grant at N+1, and tx_start and req_ready high during cycle N+2.
  - Between bytes of one message: at most 1 cycle after tx_busy falls, tx_start pulses again.
- Fairness:
  - With all requesters valid, grants rotate 0,1,2,3,0,...
  - A requester released by MAX_BURST re-arbitrates behind the others.
- Simultaneous events:
  - A new req_valid from a non-owner is ignored until release.
  - Requests arriving in the release cycle are seen in the following IDLE cycle.
- req_last sampled on a byte that also hits MAX_BURST: a single release; ptr advances once.
- Reset mid-byte: outputs clear immediately. The transmitter has its own reset; no partial-state recovery.
- Width rules:
  - count is clog2(MAX_BURST+1) bits and saturates at MAX_BURST.
  - ptr is clog2(NUM_REQ) bits and wraps modulo NUM_REQ, not a power of two.

Decomposition:
- Shared header, alongside the existing stage header: state encodings IDLE/LOAD/WAIT_BUSY/WAIT_DONE and BUSY_TIMEOUT=4.
- Sub-module uart_rr_pick: combinational rotate-priority picker.
  - Inputs: req vector and ptr.
  - Outputs: one-hot grant and valid flag.
  - Reusable by a future receiver-side dispatcher.

Test Plan:
- Single message: req_valid[2]=1 with bytes 0x41,0x42,0x43, last on 0x43; transmitter model holds busy 10 cycles.
  - tx_data sequence is 0x41,0x42,0x43; three req_ready[2] pulses.
  - grant=0100 throughout, then 0000; ptr=3.
- Round robin: all four valid with single-byte messages 0xA0+i, last=1.
  - Grant order 0,1,2,3,0; tx_data sequence 0xA0,0xA1,0xA2,0xA3,0xA0.
- Burst limit: MAX_BURST=16, requester 1 streams 20 bytes with no last, requester 3 also valid.
  - Exactly 16 bytes from 1, then grant=1000; requester 1 resumes afterward.
- Owner stall: requester 0 drops valid after 2 of 4 bytes for 50 cycles while requester 1 is valid.
  - grant stays 0001, no tx_start during the stall, bytes 3 and 4 follow, then requester 1 is served.
- Lost handshake: tx_busy held 0 after tx_start.
  - WAIT_DONE entered 4 cycles later; next byte tx_start 1 cycle after that.
- Reset mid-message: reset=0 while in WAIT_DONE.
  - grant, tx_start, req_ready, tx_data read 0 in the same cycle.
  - After release, the first request from requester 2 is granted with ptr starting at 0.

Source files
------------

// File: rtl/uart_tx_arbiter_pkg.sv
// ---------------------------------------------------------------------------
// uart_tx_arbiter_pkg
// Shared definitions for the UART transmit arbiter and its round-robin picker:
//   - arb_state_e   : arbiter FSM encodings (IDLE / LOAD / WAIT_BUSY / WAIT_DONE)
//   - BUSY_TIMEOUT  : cycles to wait for tx_busy to rise before giving up on
//                     the start handshake
//   - TIMER_W       : width of the handshake timer
// ---------------------------------------------------------------------------
package uart_tx_arbiter_pkg;

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        LOAD      = 2'd1,
        WAIT_BUSY = 2'd2,
        WAIT_DONE = 2'd3
    } arb_state_e;

    localparam int BUSY_TIMEOUT = 4;
    localparam int TIMER_W      = $clog2(BUSY_TIMEOUT);

endpackage

// File: rtl/uart_rr_pick.sv
// ---------------------------------------------------------------------------
// uart_rr_pick
// Combinational rotate-priority picker. Searches req upward starting at ptr,
// wrapping at N, and returns the first set bit as a one-hot grant.
// Ports:
//   req   in  N      request vector
//   ptr   in  PTR_W  index the search starts from (0..N-1)
//   grant out N      one-hot winner, all zero if no request
//   valid out 1      at least one request was set
// ---------------------------------------------------------------------------
module uart_rr_pick
    import uart_tx_arbiter_pkg::*;
#(
    parameter int N     = 4,
    parameter int PTR_W = 2
) (
    input  logic [N-1:0]     req,
    input  logic [PTR_W-1:0] ptr,
    output logic [N-1:0]     grant,
    output logic             valid
);

    // NOTE: every variable written here gets a default before any branch, so
    // no path leaves it unassigned and no latch is inferred.
    always_comb begin
        logic [PTR_W-1:0] idx;
        grant = '0;
        valid = 1'b0;
        idx   = '0;
        // Explicit modulo keeps the wrap correct when N is not a power of two.
        for (int k = 0; k < N; k++) begin
            idx = PTR_W'((int'(ptr) + k) % N);
            if (!valid && req[idx]) begin
                grant[idx] = 1'b1;
                valid      = 1'b1;
            end
        end
    end

endmodule

// File: rtl/uart_tx_arbiter.sv
// ---------------------------------------------------------------------------
// uart_tx_arbiter
// Shares one UART transmitter between NUM_REQ byte-stream requesters. Grants
// are round-robin at message granularity: the owner keeps the transmitter
// until it sends a byte flagged last or MAX_BURST bytes have gone out.
// Ports:
//   clk        in  1                  system clock
//   reset      in  1                  asynchronous active-low reset
//   req_valid  in  NUM_REQ            requester i offers a byte
//   req_data   in  NUM_REQ*Word_Len   byte of requester i at [i*Word_Len +: Word_Len]
//   req_last   in  NUM_REQ            offered byte ends requester i's message
//   req_ready  out NUM_REQ            one-cycle pulse: byte of requester i accepted
//   grant      out NUM_REQ            one-hot current owner, zero when idle
//   tx_start   out 1                  one-cycle pulse to start a UART word
//   tx_data    out Word_Len           byte being transmitted (held until next start)
//   tx_busy    in  1                  transmitter busy
// All outputs are registered.
// ---------------------------------------------------------------------------
module uart_tx_arbiter
    import uart_tx_arbiter_pkg::*;
#(
    parameter int NUM_REQ   = 4,
    parameter int Word_Len  = 8,
    parameter int MAX_BURST = 16
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic [NUM_REQ-1:0]           req_valid,
    input  logic [NUM_REQ*Word_Len-1:0]  req_data,
    input  logic [NUM_REQ-1:0]           req_last,
    output logic [NUM_REQ-1:0]           req_ready,
    output logic [NUM_REQ-1:0]           grant,
    output logic                         tx_start,
    output logic [Word_Len-1:0]          tx_data,
    input  logic                         tx_busy
);

    localparam int IDX_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
    localparam int CNT_W = $clog2(MAX_BURST + 1);

    localparam logic [CNT_W-1:0]   BURST_MAX  = CNT_W'(MAX_BURST);
    localparam logic [IDX_W-1:0]   LAST_IDX   = IDX_W'(NUM_REQ - 1);
    localparam logic [TIMER_W-1:0] TIMER_LAST = TIMER_W'(BUSY_TIMEOUT - 1);

    arb_state_e           state, state_next;
    logic [IDX_W-1:0]     owner, owner_next;
    logic [IDX_W-1:0]     ptr, ptr_next;
    logic [CNT_W-1:0]     count, count_next;
    logic [TIMER_W-1:0]   timer, timer_next;
    logic                 last_q, last_next;
    logic [NUM_REQ-1:0]   grant_next, req_ready_next;
    logic                 tx_start_next;
    logic [Word_Len-1:0]  tx_data_next;

    logic [NUM_REQ-1:0]   pick_grant;
    logic                 pick_valid;
    logic [IDX_W-1:0]     pick_idx;
    logic                 issue;

    uart_rr_pick #(
        .N     (NUM_REQ),
        .PTR_W (IDX_W)
    ) u_pick (
        .req   (req_valid),
        .ptr   (ptr),
        .grant (pick_grant),
        .valid (pick_valid)
    );

    always_comb begin
        pick_idx = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (pick_grant[i]) pick_idx = IDX_W'(i);
        end
    end

    always_comb begin
        state_next     = state;
        owner_next     = owner;
        ptr_next       = ptr;
        count_next     = count;
        timer_next     = timer;
        last_next      = last_q;
        grant_next     = grant;
        req_ready_next = '0;
        tx_start_next  = 1'b0;
        tx_data_next   = tx_data;
        issue          = 1'b0;

        case (state)
            IDLE: begin
                if (pick_valid) begin
                    grant_next = pick_grant;
                    owner_next = pick_idx;
                    count_next = '0;
                    state_next = LOAD;
                end
            end
            LOAD: begin
                // Message lock: a stalled owner keeps the grant.
                if (req_valid[owner] && !tx_busy) issue = 1'b1;
            end
            WAIT_BUSY: begin
                // Lost-handshake guard: move on even if tx_busy never rises.
                if (tx_busy || timer == TIMER_LAST) state_next = WAIT_DONE;
                else                                 timer_next = timer + TIMER_W'(1);
            end
            WAIT_DONE: begin
                if (!tx_busy) begin
                    if (last_q || count == BURST_MAX) begin
                        grant_next = '0;
                        ptr_next   = (owner == LAST_IDX) ? '0 : owner + IDX_W'(1);
                        state_next = IDLE;
                    end else if (req_valid[owner]) begin
                        // Issue straight from here so the next byte starts one
                        // cycle after tx_busy falls; LOAD only absorbs stalls.
                        issue = 1'b1;
                    end else begin
                        state_next = LOAD;
                    end
                end
            end
            default: state_next = IDLE;
        endcase

        if (issue) begin
            tx_data_next          = req_data[int'(owner)*Word_Len +: Word_Len];
            tx_start_next         = 1'b1;
            req_ready_next[owner] = 1'b1;
            last_next             = req_last[owner];
            count_next            = (count == BURST_MAX) ? count : count + CNT_W'(1);
            timer_next            = '0;
            state_next            = WAIT_BUSY;
        end
    end

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values, independent of statement order.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state     <= IDLE;
            owner     <= '0;
            ptr       <= '0;
            count     <= '0;
            timer     <= '0;
            last_q    <= 1'b0;
            grant     <= '0;
            req_ready <= '0;
            tx_start  <= 1'b0;
            tx_data   <= '0;
        end else begin
            state     <= state_next;
            owner     <= owner_next;
            ptr       <= ptr_next;
            count     <= count_next;
            timer     <= timer_next;
            last_q    <= last_next;
            grant     <= grant_next;
            req_ready <= req_ready_next;
            tx_start  <= tx_start_next;
            tx_data   <= tx_data_next;
        end
    end

endmodule
